// File: rtl/median_window_feeder_if.sv
// Pixel stream in / 3x3 window burst out, shared by the raster source, the window feeder and the median stage.
interface median_window_feeder_if #(
    parameter int unsigned W = 8
);
    logic [W-1:0] PI;
    logic         PVAL;
    logic         PRDY;
    logic [W-1:0] DO;
    logic         DSI;
    logic         MED_DONE;

    // master = window feeder, slave = pixel source plus median stage
    modport master (input PI, PVAL, MED_DONE, output PRDY, DO, DSI);
    modport slave  (output PI, PVAL, MED_DONE, input PRDY, DO, DSI);
endinterface

// File: rtl/median_window_feeder.sv
// 3x3 window feeder for the median filter: two line buffers, emits each valid window as a 9-byte burst.
// Optional MEDWIN_STATS_EN adds the per-frame window counter port WIN_CNT.
module median_window_feeder #(
    parameter int unsigned W     = 8,
    parameter int unsigned IMG_W = 720,
    parameter int unsigned IMG_H = 576
) (
    input  logic                    CLK,
    input  logic                    nRST,
    median_window_feeder_if.master  bus
`ifdef MEDWIN_STATS_EN
    ,
    output logic [$clog2(IMG_W*IMG_H)-1:0] WIN_CNT
`endif
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        BURST = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [3:0]    k;
    logic [W-1:0]  pix;
    logic [W-1:0]  lb0_q;
    logic [W-1:0]  lb1_q;
    logic [W-1:0]  win [9];
    logic [W-1:0]  lb0 [IMG_W];
    logic [W-1:0]  lb1 [IMG_W];
    logic          med_done_q;
    logic          prdy;
    logic          dsi;
    logic [W-1:0]  dout;

    logic col_last;
    logic row_last;
    logic is_win;

    assign col_last = (col == CW'(IMG_W - 1));
    assign row_last = (row == RW'(IMG_H - 1));
    assign is_win   = (row >= RW'(2)) && (col >= CW'(2));

    assign bus.PRDY = prdy;
    assign bus.DO   = dout;
    assign bus.DSI  = dsi;

    // Line buffers: lb0 holds the previous line, lb1 the one before; not reset, rows 0-1 never reach the output
    always_ff @(posedge CLK) begin
        if (state == LOAD) begin
            lb1[col] <= lb0_q;
            lb0[col] <= pix;
        end
    end

    // Window FSM; win[] is row-major, top (oldest) row first, leftmost (oldest) column first
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            k          <= '0;
            pix        <= '0;
            lb0_q      <= '0;
            lb1_q      <= '0;
            for (int i = 0; i < 9; i++) win[i] <= '0;
            dout       <= '0;
            dsi        <= 1'b0;
            prdy       <= 1'b0;
            med_done_q <= 1'b0;
        end else begin
            med_done_q <= bus.MED_DONE;
            case (state)
                IDLE: begin
                    prdy <= 1'b1;
                    if (bus.PVAL && prdy) begin
                        pix   <= bus.PI;
                        lb0_q <= lb0[col];
                        lb1_q <= lb1[col];
                        prdy  <= 1'b0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    win[0] <= win[1];
                    win[1] <= win[2];
                    win[2] <= lb1_q;
                    win[3] <= win[4];
                    win[4] <= win[5];
                    win[5] <= lb0_q;
                    win[6] <= win[7];
                    win[7] <= win[8];
                    win[8] <= pix;
                    if (col_last) begin
                        col <= '0;
                        row <= row_last ? '0 : row + RW'(1);
                    end else begin
                        col <= col + CW'(1);
                    end
                    if (is_win) begin
                        // old win[1] is the new top-left byte, so the burst starts on the next cycle
                        state <= BURST;
                        k     <= '0;
                        dsi   <= 1'b1;
                        dout  <= win[1];
                    end else begin
                        state <= IDLE;
                        prdy  <= 1'b1;
                    end
                end
                BURST: begin
                    if (k == 4'd8) begin
                        state <= WAIT;
                        dsi   <= 1'b0;
                        dout  <= '0;
                    end else begin
                        k    <= k + 4'd1;
                        dout <= win[k + 4'd1];
                    end
                end
                WAIT: begin
                    if (bus.MED_DONE && !med_done_q) begin
                        state <= IDLE;
                        prdy  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEDWIN_STATS_EN
    localparam int unsigned CNT_W = $clog2(IMG_W * IMG_H);

    logic [CNT_W-1:0] win_cnt;
    logic             frame_end;

    // Counts windows per frame; the frame's last window is counted, held one cycle, then cleared
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            win_cnt   <= '0;
            frame_end <= 1'b0;
        end else begin
            frame_end <= 1'b0;
            if (frame_end) begin
                win_cnt <= '0;
            end else if (state == LOAD && is_win) begin
                if (win_cnt != '1) win_cnt <= win_cnt + CNT_W'(1);
                frame_end <= col_last && row_last;
            end
        end
    end

    assign WIN_CNT = win_cnt;
`endif

endmodule

// File: tb/tb_median_window_feeder.sv
// Self-checking bench for median_window_feeder on a 4x4 image; build with MEDWIN_STATS_EN to also check WIN_CNT.
module tb_median_window_feeder;

    localparam int W     = 8;
    localparam int IMG_W = 4;
    localparam int IMG_H = 4;
    localparam int NPIX  = IMG_W * IMG_H;

    logic CLK = 1'b0;
    logic nRST;

    always #5 CLK = ~CLK;

    median_window_feeder_if #(.W(W)) bus ();

`ifdef MEDWIN_STATS_EN
    logic [3:0] win_cnt;
`endif

    median_window_feeder #(.W(W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
`ifdef MEDWIN_STATS_EN
        ,
        .WIN_CNT (win_cnt)
`endif
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int m_idx    = 0;
    int drv_idx  = 0;
    int n_bursts = 0;
    int run      = 0;
    int exp_wc   = 0;
    int mr;
    int mc;
    bit dsi_d    = 1'b0;
    bit clr_next = 1'b0;
    bit lastw;
    logic [7:0] img [IMG_H][IMG_W];
    int         xfer_cyc [NPIX];
    logic [7:0] exp_q [$];
    logic [7:0] cap_q [$];
    int         start_q [$];
    bit         last_q [$];

    logic [7:0] first_exp [9] = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};
    logic [7:0] last_exp  [9] = '{8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23, 8'h31, 8'h32, 8'h33};

    typedef struct {
        bit         burst_done;
        logic [7:0] pat;
        int         exit_at;
    } hs_vec_t;

    hs_vec_t hs_tab [5];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pat(input int idx);
        return 8'((idx / IMG_W) * 16 + (idx % IMG_W));
    endfunction

    // Reference model on rising edges, output monitor on falling edges
    always @(posedge CLK or negedge CLK) begin
        if (CLK) begin
            cyc++;
            if (!nRST) begin
                m_idx = 0;
                exp_q.delete();
                start_q.delete();
                last_q.delete();
                dsi_d    = 1'b0;
                run      = 0;
                exp_wc   = 0;
                clr_next = 1'b0;
            end else if (bus.PVAL && bus.PRDY) begin
                mr = m_idx / IMG_W;
                mc = m_idx % IMG_W;
                img[mr][mc] = bus.PI;
                xfer_cyc[m_idx] = cyc;
                if (mr >= 2 && mc >= 2) begin
                    for (int dr = 0; dr < 3; dr++)
                        for (int dc = 0; dc < 3; dc++)
                            exp_q.push_back(img[mr-2+dr][mc-2+dc]);
                    start_q.push_back(cyc);
                    last_q.push_back(mr == IMG_H - 1 && mc == IMG_W - 1);
                end
                m_idx = (m_idx + 1) % NPIX;
            end
        end else if (nRST) begin
            if (clr_next) begin
                exp_wc   = 0;
                clr_next = 1'b0;
            end
            if (bus.DSI) begin
                if (!dsi_d) begin
                    if (start_q.size() == 0) begin
                        check("dsi_unexpected", 1, 0);
                    end else begin
                        check("dsi_latency", cyc, start_q.pop_front() + 1);
                        lastw = last_q.pop_front();
                        if (exp_wc < 15) exp_wc++;
                        clr_next = lastw;
                    end
                end
                run++;
                if (exp_q.size() == 0) check("burst_extra_byte", int'(bus.DO), -1);
                else check("burst_byte", int'(bus.DO), int'(exp_q.pop_front()));
                cap_q.push_back(bus.DO);
            end else begin
                if (dsi_d) begin
                    check("burst_len", run, 9);
                    n_bursts++;
                end
                run = 0;
                check("do_idle_zero", int'(bus.DO), 0);
            end
            dsi_d = bus.DSI;
`ifdef MEDWIN_STATS_EN
            check("win_cnt", int'(win_cnt), exp_wc);
`endif
        end
    end

    // Pixel source plus median-stage stand-in: done pulse a few cycles after each burst
    task automatic run_traffic(input int budget, input int want, input int pval_pct, input bit rnd);
        int b0;
        int timer;
        bit armed;
        bit dsi_prev;
        bit tx;
        bit done;
        b0 = n_bursts;
        timer = 0;
        armed = 1'b0;
        done = 1'b0;
        dsi_prev = bus.DSI;
        bus.MED_DONE = 1'b0;
        bus.PVAL = rnd ? ($urandom_range(0, 99) < pval_pct) : 1'b1;
        bus.PI   = rnd ? 8'($urandom) : pat(drv_idx);
        for (int i = 0; i < budget && !done; i++) begin
            tx = bus.PVAL && bus.PRDY;
            @(posedge CLK); #1;
            if (tx) drv_idx = (drv_idx + 1) % NPIX;
            if (dsi_prev && !bus.DSI) begin
                armed = 1'b1;
                timer = rnd ? int'($urandom_range(0, 6)) : 5;
            end
            dsi_prev = bus.DSI;
            bus.MED_DONE = 1'b0;
            if (armed) begin
                if (timer == 0) begin
                    bus.MED_DONE = 1'b1;
                    armed = 1'b0;
                end else begin
                    timer--;
                end
            end
            if ((n_bursts - b0) >= want && bus.PRDY) done = 1'b1;
            bus.PVAL = !done && (rnd ? ($urandom_range(0, 99) < pval_pct) : 1'b1);
            bus.PI   = rnd ? 8'($urandom) : pat(drv_idx);
        end
        bus.PVAL = 1'b0;
        bus.MED_DONE = 1'b0;
        check("traffic_done", int'(done), 1);
    endtask

    task automatic full_frame();
        int b0;
        b0 = n_bursts;
        cap_q.delete();
        drv_idx = 0;
        run_traffic(400, 4, 100, 1'b0);
        check("frame_bursts", n_bursts - b0, 4);
        check("frame_bytes", cap_q.size(), 36);
        if (cap_q.size() == 36) begin
            for (int i = 0; i < 9; i++) begin
                check("first_burst", int'(cap_q[i]), int'(first_exp[i]));
                check("last_burst", int'(cap_q[27 + i]), int'(last_exp[i]));
            end
        end
        for (int i = 0; i < 10; i++) check("warmup_pacing", xfer_cyc[i + 1] - xfer_cyc[i], 2);
    endtask

    task automatic to_wait(input bit bd);
        bit seen;
        bit tx;
        seen = 1'b0;
        bus.MED_DONE = 1'b0;
        bus.PVAL = 1'b1;
        bus.PI = 8'($urandom);
        for (int i = 0; i < 200; i++) begin
            tx = bus.PVAL && bus.PRDY;
            @(posedge CLK); #1;
            if (tx) drv_idx = (drv_idx + 1) % NPIX;
            bus.PI = 8'($urandom);
            if (bus.DSI) begin
                seen = 1'b1;
                bus.PVAL = 1'b0;
                bus.MED_DONE = bd;
            end else if (seen) begin
                break;
            end
        end
        bus.PVAL = 1'b0;
        check("to_wait_reached", int'(seen && !bus.DSI), 1);
    endtask

    task automatic release_reset();
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK); #1;
        check("rst_prdy_after_release", int'(bus.PRDY), 1);
    endtask

    initial begin
        int cnt;
        bit tx;
        hs_tab[0] = '{burst_done: 1'b0, pat: 8'b0000_0001, exit_at: 1};
        hs_tab[1] = '{burst_done: 1'b0, pat: 8'b0000_1111, exit_at: 1};
        hs_tab[2] = '{burst_done: 1'b1, pat: 8'b0000_0000, exit_at: 99};
        hs_tab[3] = '{burst_done: 1'b1, pat: 8'b1111_0011, exit_at: 5};
        hs_tab[4] = '{burst_done: 1'b0, pat: 8'b0000_0110, exit_at: 2};

        nRST = 1'b0;
        bus.PVAL = 1'b0;
        bus.PI = '0;
        bus.MED_DONE = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_dsi", int'(bus.DSI), 0);
        check("rst_do", int'(bus.DO), 0);
        release_reset();

        full_frame();

        // Done handshake table: MED_DONE level during burst, then per-cycle pattern in WAIT
        for (int v = 0; v < 5; v++) begin
            to_wait(hs_tab[v].burst_done);
            check("hs_wait_prdy", int'(bus.PRDY), 0);
            for (int i = 0; i < 8; i++) begin
                bus.MED_DONE = hs_tab[v].pat[i];
                @(posedge CLK); #1;
                check($sformatf("hs%0d_prdy_c%0d", v, i), int'(bus.PRDY), int'(i + 1 >= hs_tab[v].exit_at));
            end
            if (!bus.PRDY) begin
                bus.MED_DONE = 1'b0;
                @(posedge CLK); #1;
                bus.MED_DONE = 1'b1;
                @(posedge CLK); #1;
                check("hs_recover", int'(bus.PRDY), 1);
            end
            bus.MED_DONE = 1'b0;
        end

        run_traffic(4000, 12, 60, 1'b1);

        // Reset after the 4th burst byte, then a clean frame
        cnt = 0;
        bus.PVAL = 1'b1;
        for (int i = 0; i < 200 && cnt < 4; i++) begin
            tx = bus.PVAL && bus.PRDY;
            @(posedge CLK); #1;
            if (tx) drv_idx = (drv_idx + 1) % NPIX;
            bus.PI = 8'($urandom);
            if (bus.DSI) cnt++;
        end
        bus.PVAL = 1'b0;
        check("mid_burst_reached", cnt, 4);
        @(negedge CLK);
        #1;
        nRST = 1'b0;
        #1;
        check("rst_mid_dsi", int'(bus.DSI), 0);
        check("rst_mid_do", int'(bus.DO), 0);
        repeat (2) @(posedge CLK);
        release_reset();
        full_frame();

        check("exp_q_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
